lfu_btn_cond: RTL and testbench
===============================

// Module: lfu_btn_cond
// PURPOSE
//  Input conditioner directly upstream of the lfu block. Takes five raw,
//  asynchronous push-buttons and synchronises and debounces them. Turns each
//  clean press into a one-cycle, one-hot press pulse that the lfu usage
//  counters consume. Also generates the free-running one-second tick used
//  for LFU aging/timing.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000    cycles a synced input must differ from the
//                                debounced state before that state flips (>=2)
//  TICK_CYCLES      100_000_000  clk cycles per sec_tick pulse (>=2)
// PORTS
//  clk          in   1  system clock, rising-edge
//  rst          in   1  asynchronous, active-low reset
//  b1..b5       in   1  raw button inputs, asynchronous, active-high
//  p1..p5       out  1  press pulse, one cycle; at most one high per cycle
//  multi_press  out  1  one-cycle pulse: press rejected as a chord
//  held         out  5  debounced level of each button {b5..b1}
//  sec_tick     out  1  one-cycle pulse every TICK_CYCLES cycles
// BEHAVIOUR
//  - Reset (rst=0, async): all sync flops, debounced states, debounce
//    counters, tick counter and all outputs go to 0. No output pulses are
//    produced while in reset or on release of reset.
//  - Sync: two flops per button (s1 <= bN; s2 <= s1). s2 is the only
//    internal use of bN.
//  - Debounce, per button:
//    - On s2 == held[N]: cnt <= 0.
//    - Otherwise, if cnt == DEBOUNCE_CYCLES-1: held[N] <= s2, cnt <= 0.
//    - Otherwise: cnt++.
//    - cnt width = $clog2(DEBOUNCE_CYCLES).
//    - Any glitch shorter than DEBOUNCE_CYCLES synced cycles is ignored.
//  - Rise detect: rise[N] = held_next[N] & ~held[N], evaluated on the edge
//    where held[N] flips 0->1. Release (1->0) produces no pulse.
//  - Arbitration (registered, same edge as the held flip):
//    - pN = 1 iff rise[N] is the only rise this edge and no other button
//      is already held.
//    - Otherwise, if any rise occurred, multi_press = 1 and no pN is
//      asserted.
//    - All pulse outputs are forced to 0 on the following edge unless the
//      condition recurs.
//  - Latency: raw bN held high from rising edge E0 -> pN high for exactly
//    one cycle, starting after edge E0+DEBOUNCE_CYCLES+1.
//  - Held through reset: after rst deasserts, a button still pressed
//    debounces from 0 and yields one press pulse at the normal latency.
//  - Tick: tcnt counts 0..TICK_CYCLES-1 and wraps to 0.
//    - sec_tick = 1 in the cycle tcnt == TICK_CYCLES-1, registered.
//    - First tick occurs TICK_CYCLES cycles after reset release.
//    - The tick is independent of button activity.
//  - Reset asserted mid-debounce or mid-pulse: the in-progress pulse is
//    cleared immediately and counters restart from 0.
// TESTING  (DEBOUNCE_CYCLES=4, TICK_CYCLES=10)
//  1 Reset with b=5'b00001 held -> all outputs 0 during reset; p1 is the
//    only pulse, one cycle, 5 edges after release; held=5'b00001.
//  2 b2 toggles 1,0,1,0 every cycle for 8 cycles, then 0 -> no pulse,
//    held stays 0.
//  3 b3 pressed, held 20 cycles, released, pressed again -> exactly two p3
//    pulses; none on release; held[2] falls 4-5 cycles after release.
//  4 b1 and b4 rise together -> multi_press one cycle, p1..p5 stay 0.
//    b4 held, then b2 pressed -> multi_press, no p2.
//  5 Free-run 35 cycles after reset -> sec_tick high on cycles 10, 20, 30
//    only. Assert rst for 1 cycle at cycle 25 -> next tick 10 cycles after
//    release.
//  6 Every cycle, check $countones({p1..p5,multi_press}) <= 1 under random
//    raw input stimulus.

Source files
------------

// File: rtl/lfu_btn_cond.sv
// Button conditioner ahead of the lfu block: two-flop sync, per-button debounce,
// single-press arbitration into one-hot pulses, and a free-running second tick.
module lfu_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  input  logic       b5,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic       p4,
  output logic       p5,
  output logic       multi_press,
  output logic [4:0] held,
  output logic       sec_tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_CYCLES - 1);

  logic [4:0]    w_raw;
  logic [4:0]    r_s1;
  logic [4:0]    r_s2;
  logic [4:0]    r_held;
  logic [4:0]    w_held_next;
  logic [4:0]    w_differ;
  logic [4:0]    w_expire;
  logic [CW-1:0] r_cnt      [5];
  logic [CW-1:0] w_cnt_next [5];
  logic [4:0]    w_rise;
  logic          w_any_rise;
  logic          w_single;
  logic [4:0]    r_press;
  logic          r_multi;
  logic [TW-1:0] r_tcnt;
  logic          r_tick;

  assign w_raw = {b5, b4, b3, b2, b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // A button's counter only advances while its synced level disagrees with
  // the debounced level; any agreement restarts the qualification window.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_deb
      assign w_differ[gi]    = r_s2[gi] ^ r_held[gi];
      assign w_expire[gi]    = w_differ[gi] && (r_cnt[gi] == CNT_LAST);
      assign w_held_next[gi] = w_expire[gi] ? r_s2[gi] : r_held[gi];
      assign w_cnt_next[gi]  = (!w_differ[gi] || w_expire[gi]) ? '0
                                                                  : r_cnt[gi] + CW'(1);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_held <= w_held_next;
      for (int i = 0; i < 5; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  // A press is accepted only if it is the sole new press and nothing else is
  // already down; everything else is reported as a chord.
  assign w_rise     = w_held_next & ~r_held;
  assign w_any_rise = |w_rise;
  assign w_single   = w_any_rise && ((w_rise & (w_rise - 5'd1)) == 5'd0) && (r_held == 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_press <= '0;
      r_multi <= 1'b0;
    end else begin
      r_press <= w_single ? w_rise : 5'd0;
      r_multi <= w_any_rise && !w_single;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tcnt <= (r_tcnt == TCNT_LAST) ? '0 : r_tcnt + TW'(1);
      r_tick <= (r_tcnt == TCNT_LAST);
    end
  end

  assign p1          = r_press[0];
  assign p2          = r_press[1];
  assign p3          = r_press[2];
  assign p4          = r_press[3];
  assign p5          = r_press[4];
  assign multi_press = r_multi;
  assign held        = r_held;
  assign sec_tick    = r_tick;

endmodule

// File: tb/tb_lfu_btn_cond.sv
// Directed and random checks of lfu_btn_cond against a window-based model of
// debounce, arbitration and tick timing.
module tb_lfu_btn_cond;
  localparam int D = 4;
  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] b   = 5'd0;
  logic       p1, p2, p3, p4, p5, multi_press, sec_tick;
  logic [4:0] held;
  logic [4:0] p_vec;

  assign p_vec = {p5, p4, p3, p2, p1};

  always #5 clk = ~clk;

  lfu_btn_cond #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]), .b5(b[4]),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5),
    .multi_press(multi_press), .held(held), .sec_tick(sec_tick)
  );

  int checks = 0;
  int errors = 0;

  // Model: raw samples per edge since reset release; edge index counts from 0.
  logic [4:0] raw_q[$];
  logic [4:0] m_held, m_p;
  logic       m_multi, m_tick;
  int         m_e;
  int         pcnt[5];
  int         mcnt, tickcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] synced_at(int e);
    if (e < 2) return 5'd0;
    return raw_q[e-2];
  endfunction

  task automatic model_reset();
    raw_q.delete();
    m_held = '0; m_p = '0; m_multi = 1'b0; m_tick = 1'b0; m_e = 0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) pcnt[i] = 0;
    mcnt = 0; tickcnt = 0;
  endtask

  // Level flips once the last D synced samples all disagree with it.
  task automatic model_edge();
    logic [4:0] nh, rise;
    raw_q.push_back(b);
    nh = m_held;
    for (int n = 0; n < 5; n++) begin
      bit flip;
      logic [4:0] s;
      flip = (m_e >= D - 1);
      for (int j = m_e - D + 1; j <= m_e; j++) begin
        if (j >= 0) begin
          s = synced_at(j);
          if (s[n] == m_held[n]) flip = 0;
        end
      end
      if (flip) nh[n] = ~m_held[n];
    end
    rise = nh & ~m_held;
    if (rise != 0 && $countones(rise) == 1 && m_held == 0) begin
      m_p = rise; m_multi = 1'b0;
    end else if (rise != 0) begin
      m_p = 5'd0; m_multi = 1'b1;
    end else begin
      m_p = 5'd0; m_multi = 1'b0;
    end
    m_tick = ((m_e + 1) % T == 0);
    m_held = nh;
    m_e++;
  endtask

  task automatic check_outputs();
    chk("p", {27'd0, p_vec}, {27'd0, m_p});
    chk("multi", {31'd0, multi_press}, {31'd0, m_multi});
    chk("held", {27'd0, held}, {27'd0, m_held});
    chk("tick", {31'd0, sec_tick}, {31'd0, m_tick});
    chk("onehot", {31'd0, ($countones({p_vec, multi_press}) <= 1)}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    for (int i = 0; i < 5; i++) pcnt[i] += int'(p_vec[i]);
    mcnt    += int'(multi_press);
    tickcnt += int'(sec_tick);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_p"}, {27'd0, p_vec}, 32'd0);
    chk({tag, "_multi"}, {31'd0, multi_press}, 32'd0);
    chk({tag, "_held"}, {27'd0, held}, 32'd0);
    chk({tag, "_tick"}, {31'd0, sec_tick}, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    model_reset();
    check_zero("rst_async");
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_counts();

    // 1: button 1 held through reset
    b = 5'b00001;
    #2;
    do_reset(3);
    clear_counts();
    repeat (12) step();
    chk("t1_p1_count", pcnt[0], 1);
    chk("t1_other_p", pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4] + mcnt, 0);
    chk("t1_held", {27'd0, held}, 32'd1);
    b = 5'd0;
    repeat (8) step();

    // 2: glitching b2 never qualifies
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      b = (i % 2 == 0) ? 5'b00010 : 5'b00000;
      step();
    end
    b = 5'd0;
    repeat (8) step();
    chk("t2_held", {27'd0, held}, 32'd0);
    chk("t2_pulses", pcnt[1] + mcnt, 0);

    // 3: b3 press, hold, release, press again
    clear_counts();
    b = 5'b00100; repeat (20) step();
    b = 5'b00000; repeat (10) step();
    b = 5'b00100; repeat (20) step();
    b = 5'b00000; repeat (10) step();
    chk("t3_p3_count", pcnt[2], 2);
    chk("t3_held", {27'd0, held}, 32'd0);

    // 4: chords
    clear_counts();
    b = 5'b01001; repeat (10) step();
    b = 5'b01000; repeat (10) step();
    b = 5'b01010; repeat (10) step();
    b = 5'b00000; repeat (10) step();
    chk("t4_multi_count", mcnt, 2);
    chk("t4_p_count", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4], 0);

    // 5: tick cadence and restart after a short reset
    do_reset(1);
    clear_counts();
    repeat (24) step();
    chk("t5_ticks_before", tickcnt, 2);
    do_reset(1);
    clear_counts();
    repeat (9) step();
    chk("t5_no_early_tick", tickcnt, 0);
    step();
    chk("t5_tick_after_rst", {31'd0, sec_tick}, 32'd1);

    // 6: random raw activity with one mid-run reset
    clear_counts();
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 5; n++)
        if ($urandom_range(0, 5) == 0) b[n] = ~b[n];
      if (c == 200) do_reset(2);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
